// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and baud divider.
// Used by uart_transceiver (build option UART_PARITY_EN) and uart_rx_fifo.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    // Clocks per oversample tick, rounded to nearest and never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int div;
        div = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with occupancy count; head is presented combinationally
// and reads as zero while the FIFO is empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int RX_DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_BITS-1:0]      push_data,
    input  logic                      pop,
    output logic [DATA_BITS-1:0]      head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(RX_DEPTH):0] count
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = RX_DEPTH;

    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: shared 16x tick generator, TX serialiser and oversampled RX into a FIFO.
// Build option UART_PARITY_EN adds an even parity bit in both directions and the parity_err output.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 16_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_BITS-1:0]      tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx_busy,
    output logic                      udata_out,
    input  logic                      udata_in,
    output logic [DATA_BITS-1:0]      rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
`ifdef UART_PARITY_EN
    output logic                      parity_err,
`endif
    output logic                      overrun,
    output logic [$clog2(RX_DEPTH):0] rx_count
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [5:0] BIT_LAST  = 6'(OVERSAMPLE - 1);
    localparam logic [5:0] MID_LAST  = 6'(SAMPLE_MID - 1);
    localparam logic [5:0] STOP_LAST = 6'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    uart_state_t          tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [5:0]           tx_tick_cnt;
    logic [3:0]           tx_bit_idx;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= IDLE;
            tx_shift    <= '0;
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            udata_out   <= 1'b1;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift    <= tx_data;
`ifdef UART_PARITY_EN
                        tx_par      <= ^tx_data;
`endif
                        tx_state    <= START;
                        tx_tick_cnt <= '0;
                        tx_bit_idx  <= '0;
                        udata_out   <= 1'b0;
                        tx_ready    <= 1'b0;
                        tx_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tx_tick_cnt == BIT_LAST) begin
                            tx_tick_cnt <= '0;
                            tx_state    <= DATA;
                            udata_out   <= tx_shift[0];
                        end else begin
                            tx_tick_cnt <= tx_tick_cnt + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tx_tick_cnt == BIT_LAST) begin
                            tx_tick_cnt <= '0;
                            if (tx_bit_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                                tx_state  <= PARITY;
                                udata_out <= tx_par;
`else
                                tx_state  <= STOP;
                                udata_out <= 1'b1;
`endif
                            end else begin
                                tx_bit_idx <= tx_bit_idx + 4'd1;
                                tx_shift   <= tx_shift >> 1;
                                udata_out  <= tx_shift[1];
                            end
                        end else begin
                            tx_tick_cnt <= tx_tick_cnt + 6'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tx_tick_cnt == BIT_LAST) begin
                            tx_tick_cnt <= '0;
                            tx_state    <= STOP;
                            udata_out   <= 1'b1;
                        end else begin
                            tx_tick_cnt <= tx_tick_cnt + 6'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (tx_tick_cnt == STOP_LAST) begin
                            tx_tick_cnt <= '0;
                            tx_state    <= IDLE;
                            tx_ready    <= 1'b1;
                            tx_busy     <= 1'b0;
                        end else begin
                            tx_tick_cnt <= tx_tick_cnt + 6'd1;
                        end
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Receive side: udata_in is asynchronous, so it passes two flops before any decision.
    logic [1:0]           rx_sync;
    logic                 rx_in;
    logic                 rx_prev;
    uart_state_t          rx_state;
    logic [5:0]           rx_tick_cnt;
    logic [3:0]           rx_bit_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 stop_sample;
    logic                 par_bad;
    logic                 rx_push;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign rx_in       = rx_sync[1];
    assign stop_sample = (rx_state == STOP) && tick && (rx_tick_cnt == BIT_LAST);
    assign rx_push     = stop_sample && rx_in && !par_bad;
    assign rx_valid    = !fifo_empty;

`ifdef UART_PARITY_EN
    logic rx_par_bit;
    assign par_bad = ((^rx_shift) != rx_par_bit);
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync     <= 2'b11;
            rx_prev     <= 1'b1;
            rx_state    <= IDLE;
            rx_tick_cnt <= '0;
            rx_bit_idx  <= '0;
            rx_shift    <= '0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bit  <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            rx_sync   <= {rx_sync[0], udata_in};
            rx_prev   <= rx_in;
            frame_err <= stop_sample && (!rx_in || par_bad);
            overrun   <= rx_push && fifo_full && !rx_ready;
`ifdef UART_PARITY_EN
            parity_err <= stop_sample && par_bad;
`endif
            case (rx_state)
                // A framing error also lands here; only a fresh high-to-low edge restarts RX.
                IDLE: begin
                    if (rx_prev && !rx_in) begin
                        rx_state    <= START;
                        rx_tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_tick_cnt == MID_LAST) begin
                            rx_tick_cnt <= '0;
                            rx_bit_idx  <= '0;
                            rx_state    <= rx_in ? IDLE : DATA;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (rx_tick_cnt == BIT_LAST) begin
                            rx_tick_cnt <= '0;
                            rx_shift    <= {rx_in, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                                rx_state <= PARITY;
`else
                                rx_state <= STOP;
`endif
                            end else begin
                                rx_bit_idx <= rx_bit_idx + 4'd1;
                            end
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 6'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (rx_tick_cnt == BIT_LAST) begin
                            rx_tick_cnt <= '0;
                            rx_par_bit  <= rx_in;
                            rx_state    <= STOP;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 6'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (rx_tick_cnt == BIT_LAST) begin
                            rx_tick_cnt <= '0;
                            rx_state    <= IDLE;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 6'd1;
                        end
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DATA_BITS (DATA_BITS),
        .RX_DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver at 16 clocks per bit: TX waveform, loopback,
// framing error, glitch rejection, overrun and mid-frame reset.
module tb_uart_transceiver;

    localparam int CLK_HZ    = 16_000_000;
    localparam int BAUD      = 1_000_000;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int RX_DEPTH  = 8;
    localparam int BIT_CLK   = 16;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [DATA_BITS-1:0]      tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      tx_busy;
    logic                      udata_out;
    logic                      udata_in;
    logic [DATA_BITS-1:0]      rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun;
    logic [$clog2(RX_DEPTH):0] rx_count;
`ifdef UART_PARITY_EN
    logic                      parity_err;
`endif

    logic loopback;
    logic rx_drv;

    assign udata_in = loopback ? udata_out : rx_drv;

    uart_transceiver #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .RX_DEPTH  (RX_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .udata_out  (udata_out),
        .udata_in   (udata_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
`ifdef UART_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun),
        .rx_count   (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference line level for bit position i of a frame carrying d.
    function automatic logic line_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= DATA_BITS) return d[i-1];
`ifdef UART_PARITY_EN
        if (i == DATA_BITS + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference FIFO: the scoreboard queue doubles as occupancy while nothing is popped.
    task automatic expect_byte(input logic [7:0] d);
        if (exp_q.size() < RX_DEPTH) exp_q.push_back(d);
        else exp_ov++;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_v);
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx_drv = (i == FRAME_BITS - 1) ? stop_v : line_bit(d, i);
            wait_clk(BIT_CLK);
        end
        rx_drv = 1'b1;
    endtask

    task automatic tx_send(input logic [7:0] d);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 400) begin
            wait_clk(1);
            n++;
        end
        check("tx_ready_wait", int'(tx_ready), 1);
        wait_clk(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            wait_clk(1);
            n++;
        end
        check("rx_bytes_outstanding", exp_q.size(), 0);
    endtask

    task automatic tx_wave(input logic [7:0] d);
        int low = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        check("tx_ready_idle", int'(tx_ready), 1);
        wait_clk(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("tx_busy_in_frame", int'(tx_busy), 1);
        for (int i = 0; i < FRAME_BITS * BIT_CLK; i++) begin
            check($sformatf("tx_line_cycle%0d", i), int'(udata_out), int'(line_bit(d, i / BIT_CLK)));
            if (!tx_ready) low++;
            wait_clk(1);
        end
        check("tx_ready_low_cycles", low, FRAME_BITS * BIT_CLK);
        check("tx_ready_after", int'(tx_ready), 1);
        check("tx_busy_after", int'(tx_busy), 0);
        check("tx_line_idle", int'(udata_out), 1);
    endtask

    // Monitor: counts status pulses and checks every byte the consumer pops.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_pop_unexpected: got %0h, expected no byte", rx_data);
                end else begin
                    check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        rst_n    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        loopback = 1'b0;
        rx_drv   = 1'b1;
        wait_clk(3);
        check("rst_udata_out", int'(udata_out), 1);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_count", int'(rx_count), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        wait_clk(2);

        tx_wave(8'hA5);
        tx_wave(8'($urandom));

        loopback = 1'b1;
        rx_ready = 1'b1;
        expect_byte(8'h3C);
        tx_send(8'h3C);
        expect_byte(8'hFF);
        tx_send(8'hFF);
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom);
            expect_byte(d);
            tx_send(d);
        end
        wait_drain(400);
        check("loopback_frame_err", fe_cnt, exp_fe);
        check("loopback_overrun", ov_cnt, exp_ov);

        loopback = 1'b0;
        rx_ready = 1'b0;
        wait_clk(20);
        rx_frame(8'h55, 1'b0);
        exp_fe++;
        wait_clk(20);
        check("bad_stop_frame_err", fe_cnt, exp_fe);
        check("bad_stop_rx_count", int'(rx_count), 0);
        expect_byte(8'h12);
        rx_frame(8'h12, 1'b1);
        wait_clk(5);
        check("recover_rx_count", int'(rx_count), 1);
        rx_ready = 1'b1;
        wait_drain(50);
        rx_ready = 1'b0;

        rx_drv = 1'b0;
        wait_clk(4);
        rx_drv = 1'b1;
        wait_clk(40);
        check("glitch_rx_count", int'(rx_count), 0);
        check("glitch_frame_err", fe_cnt, exp_fe);
        d = 8'($urandom);
        expect_byte(d);
        rx_frame(d, 1'b1);
        wait_clk(5);
        check("post_glitch_rx_count", int'(rx_count), 1);
        rx_ready = 1'b1;
        wait_drain(50);

        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            expect_byte(d);
            rx_frame(d, 1'b1);
            wait_clk($urandom_range(0, 20));
        end
        wait_drain(100);

        rx_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            expect_byte(8'(k));
            rx_frame(8'(k), 1'b1);
        end
        wait_clk(5);
        check("full_rx_count", int'(rx_count), RX_DEPTH);
        check("overrun_pulses", ov_cnt, exp_ov);
        rx_ready = 1'b1;
        wait_drain(100);
        check("drained_rx_count", int'(rx_count), 0);

        loopback = 1'b1;
        tx_send(8'h00);
        wait_clk(50);
        check("line_low_before_reset", int'(udata_out), 0);
        rst_n = 1'b0;
        #1;
        check("async_reset_udata_out", int'(udata_out), 1);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(1);
        check("post_reset_tx_ready", int'(tx_ready), 1);
        check("post_reset_tx_busy", int'(tx_busy), 0);
        check("post_reset_rx_count", int'(rx_count), 0);
        check("post_reset_rx_valid", int'(rx_valid), 0);
        expect_byte(8'h81);
        tx_send(8'h81);
        wait_drain(400);

        wait_clk(5);
        check("total_frame_err", fe_cnt, exp_fe);
        check("total_overrun", ov_cnt, exp_ov);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Parametrised full-duplex UART that replaces the fixed 8-bit sender/receiver pair.
- TX: 8N1/8E1-style serialiser with a valid/ready byte interface.
- RX: 16x-oversampled deserialiser feeding an RX FIFO, with framing/overrun reporting.
- Sits between the board serial pins and system logic (LED/debug, GA host link).

Parameters:
CLK_HZ, 16_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bit/s
DATA_BITS, 8, data bits per frame (5..9)
STOP_BITS, 1, stop bits per frame (1 or 2)
RX_DEPTH, 8, RX FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  byte to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  transmitter idle, accepts tx_data this cycle
tx_busy  output  1  frame in progress on udata_out
udata_out  output  1  serial line out, idle high
udata_in  input  1  serial line in, asynchronous
rx_data  output  DATA_BITS  head of RX FIFO
rx_valid  output  1  RX FIFO non-empty
rx_ready  input  1  consumer pops head when rx_valid && rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte dropped, FIFO full
rx_count  output  $clog2(RX_DEPTH)+1  FIFO occupancy

Behaviour:
- Tick generator: free-running counter, DIV = CLK_HZ/(BAUD*16) rounded to nearest, minimum 1. One-cycle tick when the counter wraps. Shared by TX and RX.
- Reset values:
  - udata_out=1, tx_ready=1, tx_busy=0.
  - rx_valid=0, rx_data=0, rx_count=0, frame_err=0, overrun=0.
  - All counters 0; both FSMs in IDLE.
  - Reset mid-frame aborts immediately; udata_out returns high asynchronously.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Handshake completes when tx_valid && tx_ready; tx_data is latched on that edge and tx_ready drops the next cycle.
  - Each serial bit lasts exactly 16 ticks. Data goes out LSB first. STOP lasts STOP_BITS*16 ticks.
  - tx_ready re-asserts in the cycle after the last stop tick. Back-to-back frames carry no extra idle bit.
  - tx_valid without tx_ready is ignored; tx_data need not be held.
- RX path: 2-flop synchronizer on udata_in.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE -> START on a synced high-to-low transition.
  - START samples at tick 8. If the line is high (glitch), return to IDLE with no error.
  - DATA/PARITY/STOP sample every 16 ticks after that, i.e. at mid-bit.
  - Only the first stop bit is checked.
  - STOP sampled low: frame_err pulses, byte discarded, FSM returns to IDLE once the line is high.
  - STOP sampled high: byte pushed to FIFO on that cycle.
- RX FIFO: circular buffer, pointers wrap modulo RX_DEPTH.
  - rx_data is combinational from the head entry.
  - Push while full: byte dropped, overrun pulses, FIFO contents unchanged.
  - Simultaneous push and pop while full: both succeed, no overrun. Count is unchanged.
  - Pop while empty: ignored.
  - Latency: the last stop sample's tick edge to rx_valid high is 1 clk.

Optional Feature:
Macro UART_PARITY_EN.
- Defined:
  - Even parity bit inserted after the data bits on TX; checked on RX.
  - Parity mismatch pulses frame_err and discards the byte.
  - Additional output parity_err, a one-cycle pulse alongside frame_err, distinguishing the cause.
- Undefined: no parity state in either FSM, no parity_err port. Frame is start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP) shared by TX and RX.
  - OVERSAMPLE=16 and SAMPLE_MID=8 constants.
  - Function computing DIV from CLK_HZ/BAUD.
- One sub-module: uart_rx_fifo (parametrised DATA_BITS/RX_DEPTH, push/pop/full/empty/count).
- TX, RX and tick generator stay in the top.

Test Plan:
(Parameters CLK_HZ=16_000_000, BAUD=1_000_000: DIV=1, 16 clk per bit.)
- TX: send 8'hA5 -> udata_out low 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then high. tx_ready low for exactly 160 clk.
- Loopback: udata_out wired to udata_in, send 8'h3C then 8'hFF back-to-back. Required: rx_valid rises; 3C popped then FF; no frame_err or overrun.
- Framing: drive start + 8'h55 with stop bit low -> frame_err pulses once; rx_count stays 0; RX recovers and receives the next good frame 8'h12.
- Glitch: drive udata_in low for 4 clk only -> no byte pushed, no error, RX_IDLE retained.
- Overrun: RX_DEPTH=8, rx_ready=0, inject 9 bytes 8'h00..8'h08 -> rx_count=8; overrun pulses on the 9th; pops return 00..07.
- Reset: assert rst_n=0 mid-TX-data and mid-RX-frame -> udata_out=1 immediately; tx_ready=1, rx_count=0 after release; the next frame 8'h81 transfers correctly.
